// File: rtl/mem_zero_fill.sv
// Memory clear engine: writes zero words over a contiguous word range, then
// optionally reads the range back and flags the first word that is not zero.

module eqz_32 (
    input  logic [31:0] i_data,
    output logic        o_zero
);
    assign o_zero = (i_data == 32'd0);
endmodule

// Handshake: start is a level request sampled only in IDLE; there is no ready
// back-pressure. busy covers FILL/VERIFY/DRAIN, done pulses one cycle in DONE.
module mem_zero_fill #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             verify_en,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic [2:0]       dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_base;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idx;
    logic             r_ven;
    logic             r_chk_valid;
    logic [31:0]      r_chk_addr;
    logic             r_err;
    logic [31:0]      r_err_addr;

    logic             w_we;
    logic             w_re;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic             w_zero;
    logic             w_mismatch;
    logic [31:0]      w_cur_addr;

    eqz_32 u_eqz (
        .i_data (mem_rdata),
        .o_zero (w_zero)
    );

    assign w_last     = (r_idx == (r_cnt - CNT_W'(1)));
    assign w_cur_addr = r_base + 32'(r_idx);
    // r_chk_valid marks that mem_rdata this cycle answers last cycle's read.
    assign w_mismatch = r_chk_valid & ~w_zero;

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_re   = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = r_ven ? S_VERIFY : S_DONE;
                end
            end
            S_VERIFY: begin
                w_re   = 1'b1;
                w_busy = 1'b1;
                if (w_mismatch) begin
                    w_next = S_DONE;
                end else if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_base      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_ven       <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_addr  <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_chk_valid <= w_re;
            if (w_re) begin
                r_chk_addr <= w_cur_addr;
            end
            if (r_state == S_IDLE && start) begin
                r_base     <= base_addr;
                r_cnt      <= word_count;
                r_ven      <= verify_en;
                r_idx      <= '0;
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end else if (r_state == S_FILL || r_state == S_VERIFY) begin
                r_idx <= w_last ? '0 : r_idx + CNT_W'(1);
            end
            // Only the first bad word is recorded: a mismatch always leads to DONE.
            if ((r_state == S_VERIFY || r_state == S_DRAIN) && w_mismatch) begin
                r_err      <= 1'b1;
                r_err_addr <= r_chk_addr;
            end
        end
    end

    assign mem_we    = w_we;
    assign mem_re    = w_re;
    assign mem_addr  = (w_we | w_re) ? w_cur_addr : 32'd0;
    assign mem_wdata = 32'd0;
    assign busy      = w_busy;
    assign done      = w_done;
    assign err       = r_err;
    assign err_addr  = r_err_addr;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_mem_zero_fill.sv
// Bench for mem_zero_fill: a memory model with stuck non-zero cells and a
// per-cycle expected trace derived from the fill/verify timing rules.

module tb_mem_zero_fill;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             verify_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      err_addr;
  logic [2:0]       dbg_state;

  int checks = 0;
  int failures = 0;

  // Cells listed here read back non-zero regardless of writes (stuck cells).
  logic [31:0] bad_mem [logic [31:0]];
  // Expected per-cycle vector {we, re, addr, busy, done, err, err_addr}.
  logic [68:0] exp_q[$];

  mem_zero_fill #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .verify_en  (verify_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // Synchronous memory: data valid the cycle after the read; garbage otherwise.
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= bad_mem.exists(mem_addr) ? bad_mem[mem_addr] : 32'd0;
    else        mem_rdata <= $urandom;
  end

  // ---------------- reference model ----------------
  task automatic build_exp(input logic [31:0] base, input int n, input bit ven);
    int k;
    int len;
    logic we, re, bsy, dn, er;
    logic [31:0] addr, ea;
    k = -1;
    if (ven) begin
      for (int i = 0; i < n; i++)
        if (k < 0 && bad_mem.exists(base + 32'(i))) k = i;
    end
    if (n == 0)      len = 1;
    else if (!ven)   len = n + 1;
    else if (k >= 0) len = n + 3 + k;   // bad read at n+1+k, checked next cycle
    else             len = 2 * n + 2;
    exp_q.delete();
    for (int c = 1; c <= len; c++) begin
      we   = (c <= n);
      re   = ven && (c > n) && (c <= 2 * n) && (c < len);
      addr = we ? base + 32'(c - 1) : (re ? base + 32'(c - n - 1) : 32'd0);
      bsy  = (c < len);
      dn   = (c == len);
      er   = dn && (k >= 0);
      ea   = er ? base + 32'(k) : 32'd0;
      exp_q.push_back({we, re, addr, bsy, dn, er, ea});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [31:0] base, input int n, input bit ven,
                        input bit hold, input string name);
    logic [68:0] exp_v;
    logic [68:0] act;
    int c;
    build_exp(base, n, ven);
    @(negedge clock);
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(n);
    verify_en  = ven;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    base_addr  = $urandom;
    word_count = CNT_W'($urandom);
    verify_en  = 1'($urandom_range(0, 1));
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      c++;
      exp_v = exp_q.pop_front();
      act = {mem_we, mem_re, mem_addr, busy, done, err, err_addr};
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL %s cycle %0d: got {we,re,addr,busy,done,err,err_addr}=%h want %h",
                 name, c, act, exp_v);
      end
      if (mem_we) begin
        checks++;
        if (mem_wdata !== 32'd0) begin
          failures++;
          $display("FAIL %s wdata cycle %0d: got %h want 0", name, c, mem_wdata);
        end
      end
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [68:0] act;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    verify_en = 1'b0;
    repeat (3) @(negedge clock);
    act = {mem_we, mem_re, mem_addr, busy, done, err, err_addr};
    checks++;
    if (act !== 69'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got %h wdata %h want all zero", act, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_only();
    run_op(32'h100, 4, 1'b0, 1'b0, "fill_only");
  endtask

  task automatic test_verify_clean();
    run_op(32'h200, 3, 1'b1, 1'b0, "verify_clean");
  endtask

  task automatic test_verify_err();
    bad_mem[32'h302] = 32'hDEAD_0000;
    run_op(32'h300, 4, 1'b1, 1'b0, "verify_err");
    bad_mem.delete();
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || err_addr !== 32'h302 || done !== 1'b0) begin
      failures++;
      $display("FAIL err_hold: got err=%b addr=%h done=%b want 1 00000302 0", err, err_addr, done);
    end
  endtask

  task automatic test_wrap();
    run_op(32'hFFFF_FFFE, 3, 1'b0, 1'b0, "wrap_fill");
    bad_mem[32'h0] = 32'h0000_0001;
    run_op(32'hFFFF_FFFE, 3, 1'b1, 1'b0, "wrap_verify_last_bad");
    bad_mem.delete();
  endtask

  task automatic test_zero_len();
    run_op(32'h400, 0, 1'b1, 1'b0, "zero_len");
  endtask

  task automatic test_start_hold();
    run_op(32'h500, 5, 1'b0, 1'b1, "start_hold");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    start = 1'b1; base_addr = 32'h600; word_count = CNT_W'(8); verify_en = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      checks++;
      if (mem_we !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h600 + 32'(c - 1)) begin
        failures++;
        $display("FAIL reset_mid_pre cycle %0d: got we=%b busy=%b addr=%h want 1 1 %h",
                 c, mem_we, busy, mem_addr, 32'h600 + 32'(c - 1));
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({mem_we, mem_re, busy, done, mem_addr} !== 36'd0) begin
      failures++;
      $display("FAIL reset_mid_post: got we=%b re=%b busy=%b done=%b addr=%h want zeros",
               mem_we, mem_re, busy, done, mem_addr);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet %0d: got done=%b busy=%b we=%b want 0 0 0",
                 c, done, busy, mem_we);
      end
    end
    run_op(32'h700, 2, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    bad_mem[32'h801] = 32'h8000_0000;
    run_op(32'h800, 3, 1'b1, 1'b0, "b2b_err");
    bad_mem.delete();
    run_op(32'h900, 2, 1'b1, 1'b0, "b2b_clean");
    run_op(32'hA00, 1, 1'b0, 1'b0, "b2b_one");
  endtask

  task automatic test_random();
    logic [31:0] base;
    int n;
    bit ven;
    for (int it = 0; it < 25; it++) begin
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      n    = $urandom_range(0, 12);
      ven  = 1'($urandom_range(0, 1));
      if (ven && n > 0 && $urandom_range(0, 2) != 0) begin
        bad_mem[base + 32'($urandom_range(0, n - 1))] = $urandom | 32'h1;
        if ($urandom_range(0, 1) == 1)
          bad_mem[base + 32'($urandom_range(0, n - 1))] = 32'h1 << $urandom_range(0, 31);
      end
      run_op(base, n, ven, 1'($urandom_range(0, 3) == 0), "random");
      bad_mem.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_only();
    test_verify_clean();
    test_verify_err();
    test_wrap();
    test_zero_len();
    test_start_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
